regfile_write_arbiter: RTL and testbench

- Shares the N_WRITE_PORTS write ports of the multi-ported register file among N_REQ independent write requesters.
- Each requester uses a valid/ready handshake; the block grants up to N_WRITE_PORTS requests per cycle in round-robin order.
- Same-cycle grants to the same register address are suppressed.
- Granted writes are registered and driven onto the register file's en/we/wAddrs/wPorts inputs.

---
 rtl/regfile_write_arbiter.sv | 158 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port arbiter for a multi-ported register file.
// Up to N_WRITE_PORTS requesters are granted per cycle, skipping any whose
// address collides with an earlier grant in the same cycle. Granted writes
// are registered one cycle before they reach the register file.

// One registered write port. An idle port drops we but keeps its last
// address/data so the register-file inputs do not toggle needlessly.
module regfile_wport_reg #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vld_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic                  we_d, we_q;
    logic [ADDR_WIDTH-1:0] addr_d, addr_q;
    logic [DATA_WIDTH-1:0] data_d, data_q;

    // Load a new write when granted, otherwise hold address/data.
    always_comb begin
        we_d   = vld_i;
        addr_d = vld_i ? addr_i : addr_q;
        data_d = vld_i ? data_i : data_q;
    end

    // Port state; async reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign we_o   = we_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

module regfile_write_arbiter #(
    parameter int  N_REQ         = 4,
    parameter int  N_WRITE_PORTS = 2,
    parameter int  N_REGS        = 32,
    parameter int  DATA_WIDTH    = 32,
    localparam int ADDR_WIDTH    = $clog2(N_REGS)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [N_REQ-1:0]                         reqValid,
    input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]         reqAddr,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]         reqData,
    output logic [N_REQ-1:0]                         reqReady,
    output logic                                     en,
    output logic [N_WRITE_PORTS-1:0]                 we,
    output logic [N_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] wAddrs,
    output logic [N_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wPorts
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]                         rr_ptr_d, rr_ptr_q;
    logic                                     en_d, en_q;
    logic [N_REQ-1:0]                         grant;
    logic [N_WRITE_PORTS-1:0]                 port_vld;
    logic [N_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] port_addr;
    logic [N_WRITE_PORTS-1:0][DATA_WIDTH-1:0] port_data;

    // Scan requesters once around starting at rr_ptr; the k-th grant takes
    // port k. Address collisions with earlier grants are deferred so the
    // register file never sees two ports writing the same register.
    always_comb begin
        int  n_gnt;
        int  idx;
        int  last;
        logic clash;
        grant     = '0;
        port_vld  = '0;
        port_addr = '0;
        port_data = '0;
        rr_ptr_d  = rr_ptr_q;
        n_gnt     = 0;
        last      = -1;
        clash     = 1'b0;
        for (int s = 0; s < N_REQ; s++) begin
            idx = int'(rr_ptr_q) + s;
            if (idx >= N_REQ) idx = idx - N_REQ;
            for (int i = 0; i < N_REQ; i++) begin
                if (i == idx) begin
                    clash = 1'b0;
                    for (int k = 0; k < N_WRITE_PORTS; k++) begin
                        if (k < n_gnt && port_addr[k] == reqAddr[i]) clash = 1'b1;
                    end
                    if (reqValid[i] && n_gnt < N_WRITE_PORTS && !clash) begin
                        grant[i] = 1'b1;
                        for (int k = 0; k < N_WRITE_PORTS; k++) begin
                            if (k == n_gnt) begin
                                port_vld[k]  = 1'b1;
                                port_addr[k] = reqAddr[i];
                                port_data[k] = reqData[i];
                            end
                        end
                        n_gnt = n_gnt + 1;
                        last  = i;
                    end
                end
            end
        end
        if (last >= 0) begin
            rr_ptr_d = (last == N_REQ - 1) ? '0 : PTR_W'(last + 1);
        end
        en_d = |port_vld;
    end

    // Nothing is granted while reset is held.
    assign reqReady = rst ? grant : '0;

    // Round-robin pointer and register-file enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
            en_q     <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            en_q     <= en_d;
        end
    end

    assign en = en_q;

    for (genvar k = 0; k < N_WRITE_PORTS; k++) begin : g_port
        regfile_wport_reg #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_port (
            .clk    (clk),
            .rst_n  (rst),
            .vld_i  (port_vld[k]),
            .addr_i (port_addr[k]),
            .data_i (port_data[k]),
            .we_o   (we[k]),
            .addr_o (wAddrs[k]),
            .data_o (wPorts[k])
        );
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a shadow register file fed
// from the write-port outputs.
module tb_regfile_write_arbiter;

    logic             clk;
    logic             rst;
    logic [3:0]       reqValid;
    logic [3:0][4:0]  reqAddr;
    logic [3:0][31:0] reqData;
    logic [3:0]       reqReady;
    logic             en;
    logic [1:0]       we;
    logic [1:0][4:0]  wAddrs;
    logic [1:0][31:0] wPorts;

    int checks = 0;
    int errors = 0;

    logic [31:0] rf [32];

    regfile_write_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .reqValid (reqValid),
        .reqAddr  (reqAddr),
        .reqData  (reqData),
        .reqReady (reqReady),
        .en       (en),
        .we       (we),
        .wAddrs   (wAddrs),
        .wPorts   (wPorts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file written one edge after the arbiter registers a write.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++)
            if (en && we[k]) rf[wAddrs[k]] <= wPorts[k];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; reqValid = '0; reqAddr = '0; reqData = '0;
        #2;
        // 1: reset with everything valid
        reqValid = 4'hF;
        reqAddr[0] = 5'd1; reqAddr[1] = 5'd2; reqAddr[2] = 5'd3; reqAddr[3] = 5'd4;
        reqData[0] = 32'h11; reqData[1] = 32'h22; reqData[2] = 32'h33; reqData[3] = 32'h44;
        #1;
        chk("rst_ready", reqReady, 4'b0000);
        chk("rst_we", we, 2'b00);
        chk("rst_en", en, 1'b0);
        chk("rst_waddrs", wAddrs, 10'd0);
        chk("rst_wports", wPorts, 64'd0);
        tick();
        chk("rst_we_edge", we, 2'b00);
        rst = 1'b1; #1;
        chk("t1_ready", reqReady, 4'b0011);
        chk("t1_rr", dut.rr_ptr_q, 2'd0);

        // 3: continuous all-valid, distinct addresses
        tick();
        chk("t3_we0", we, 2'b11);
        chk("t3_en0", en, 1'b1);
        chk("t3_a0_0", wAddrs[0], 5'd1);
        chk("t3_a1_0", wAddrs[1], 5'd2);
        chk("t3_rr0", dut.rr_ptr_q, 2'd2);
        chk("t3_ready1", reqReady, 4'b1100);
        tick();
        chk("t3_a0_1", wAddrs[0], 5'd3);
        chk("t3_a1_1", wAddrs[1], 5'd4);
        chk("t3_d0_1", wPorts[0], 32'h33);
        chk("t3_rr1", dut.rr_ptr_q, 2'd0);
        chk("t3_ready2", reqReady, 4'b0011);
        tick();
        chk("t3_rr2", dut.rr_ptr_q, 2'd2);
        chk("t3_ready3", reqReady, 4'b1100);
        chk("t3_a0_2", wAddrs[0], 5'd1);
        tick();
        chk("t3_rr3", dut.rr_ptr_q, 2'd0);
        chk("t3_a0_3", wAddrs[0], 5'd3);

        // idle cycle
        reqValid = 4'h0; #1;
        chk("idle_ready", reqReady, 4'b0000);
        tick();
        chk("idle_we", we, 2'b00);
        chk("idle_en", en, 1'b0);
        chk("idle_addr_hold", wAddrs[0], 5'd3);
        chk("idle_rr", dut.rr_ptr_q, 2'd0);

        // 2: two sparse requesters
        reqAddr[0] = 5'd3; reqData[0] = 32'hFFFFFFFF;
        reqAddr[2] = 5'd5; reqData[2] = 32'hCCCCCCCC;
        reqValid = 4'b0101; #1;
        chk("t2_ready", reqReady, 4'b0101);
        tick();
        reqValid = 4'h0;
        chk("t2_we", we, 2'b11);
        chk("t2_en", en, 1'b1);
        chk("t2_a0", wAddrs[0], 5'd3);
        chk("t2_d0", wPorts[0], 32'hFFFFFFFF);
        chk("t2_a1", wAddrs[1], 5'd5);
        chk("t2_d1", wPorts[1], 32'hCCCCCCCC);
        chk("t2_rr", dut.rr_ptr_q, 2'd3);
        tick();
        chk("t2_rf3", rf[3], 32'hFFFFFFFF);
        chk("t2_rf5", rf[5], 32'hCCCCCCCC);

        // pointer wrap: lone grant to requester 3
        reqAddr[3] = 5'd20; reqData[3] = 32'h5A; reqValid = 4'b1000; #1;
        chk("wrap_ready", reqReady, 4'b1000);
        tick();
        reqValid = 4'h0;
        chk("wrap_rr", dut.rr_ptr_q, 2'd0);
        chk("wrap_we", we, 2'b01);
        chk("wrap_a0", wAddrs[0], 5'd20);

        // 4: address conflict
        reqAddr[0] = 5'd7; reqData[0] = 32'hA0;
        reqAddr[1] = 5'd7; reqData[1] = 32'hA1;
        reqAddr[2] = 5'd9; reqData[2] = 32'hA2;
        reqValid = 4'b0111; #1;
        chk("t4_ready0", reqReady, 4'b0101);
        tick();
        reqValid = 4'b0010;
        chk("t4_we0", we, 2'b11);
        chk("t4_a0_0", wAddrs[0], 5'd7);
        chk("t4_d0_0", wPorts[0], 32'hA0);
        chk("t4_a1_0", wAddrs[1], 5'd9);
        chk("t4_rr0", dut.rr_ptr_q, 2'd3);
        #1;
        chk("t4_ready1", reqReady, 4'b0010);
        tick();
        reqValid = 4'h0;
        chk("t4_we1", we, 2'b01);
        chk("t4_a0_1", wAddrs[0], 5'd7);
        chk("t4_d0_1", wPorts[0], 32'hA1);
        chk("t4_a1_hold", wAddrs[1], 5'd9);
        chk("t4_rr1", dut.rr_ptr_q, 2'd2);
        tick();
        chk("t4_rf7", rf[7], 32'hA1);
        chk("t4_rf9", rf[9], 32'hA2);
        chk("t4_we_idle", we, 2'b00);

        // realign pointer to 0
        reqAddr[3] = 5'd20; reqValid = 4'b1000; #1;
        chk("align_ready", reqReady, 4'b1000);
        tick();
        reqValid = 4'h0;
        chk("align_rr", dut.rr_ptr_q, 2'd0);

        // 5: single-address stream
        for (int i = 0; i < 4; i++) begin
            reqAddr[i] = 5'd10;
            reqData[i] = 32'(i);
        end
        reqValid = 4'hF; #1;
        chk("t5_ready0", reqReady, 4'b0001);
        tick();
        reqValid = 4'hE;
        chk("t5_we0", we, 2'b01);
        chk("t5_d0", wPorts[0], 32'd0);
        #1;
        chk("t5_ready1", reqReady, 4'b0010);
        tick();
        reqValid = 4'hC;
        chk("t5_we1", we, 2'b01);
        chk("t5_d1", wPorts[0], 32'd1);
        #1;
        chk("t5_ready2", reqReady, 4'b0100);
        tick();
        reqValid = 4'h8;
        chk("t5_d2", wPorts[0], 32'd2);
        #1;
        chk("t5_ready3", reqReady, 4'b1000);
        tick();
        reqValid = 4'h0;
        chk("t5_we3", we, 2'b01);
        chk("t5_d3", wPorts[0], 32'd3);
        chk("t5_a3", wAddrs[0], 5'd10);
        chk("t5_rr", dut.rr_ptr_q, 2'd0);
        tick();
        chk("t5_rf10", rf[10], 32'd3);
        chk("t5_we_idle", we, 2'b00);

        // 6: reset mid-burst
        reqAddr[0] = 5'd1; reqAddr[1] = 5'd2; reqAddr[2] = 5'd3; reqAddr[3] = 5'd4;
        reqData[0] = 32'h61; reqData[1] = 32'h62; reqData[2] = 32'h63; reqData[3] = 32'h64;
        reqValid = 4'hF; #1;
        chk("t6_ready0", reqReady, 4'b0011);
        tick();
        chk("t6_we_pre", we, 2'b11);
        rst = 1'b0; #1;
        chk("t6_we_async", we, 2'b00);
        chk("t6_en_async", en, 1'b0);
        chk("t6_waddrs_async", wAddrs, 10'd0);
        chk("t6_ready_rst", reqReady, 4'b0000);
        chk("t6_rr_rst", dut.rr_ptr_q, 2'd0);
        tick();
        chk("t6_we_held", we, 2'b00);
        rst = 1'b1; #1;
        chk("t6_ready_rel", reqReady, 4'b0011);
        tick();
        reqValid = 4'hC;
        chk("t6_a0_0", wAddrs[0], 5'd1);
        chk("t6_d0_0", wPorts[0], 32'h61);
        #1;
        chk("t6_ready1", reqReady, 4'b1100);
        tick();
        reqValid = 4'h0;
        chk("t6_a0_1", wAddrs[0], 5'd3);
        chk("t6_a1_1", wAddrs[1], 5'd4);
        chk("t6_d1_1", wPorts[1], 32'h64);
        chk("t6_rr", dut.rr_ptr_q, 2'd0);
        tick();
        chk("t6_rf1", rf[1], 32'h61);
        chk("t6_rf4", rf[4], 32'h64);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
